// File: rtl/btn_press_encoder.sv
// Button front-end for the genius game. Each of the three buttons is
// synchronised and debounced. Rising edges of the debounced vector are turned
// into 2-bit symbol codes, and each press is offered to the game FSM as one
// event over a valid/ready handshake.
module btn_press_encoder #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 5,
    parameter bit BTN_ACTIVE_LOW  = 1'b0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] btn,
    input  logic       press_ready,
    output logic       press_valid,
    output logic [1:0] press_code,
    output logic       multi_err,
    output logic       press_drop,
    output logic       any_held
);

    // Reject debounce settings the counters cannot represent.
    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > (2 ** CNT_W) - 1) begin : g_bad_cfg
        $error("btn_press_encoder: DEBOUNCE_CYCLES out of range for CNT_W");
    end

    typedef enum logic {
        IDLE,
        HELD
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [2:0]       btn_pos;
    logic [2:0]       s1;
    logic [2:0]       s2;
    logic [2:0]       deb;
    logic [2:0]       deb_prev;
    logic [CNT_W-1:0] cnt [3];

    logic [2:0]       rise;
    logic             rise_one;
    logic             rise_multi;
    logic [1:0]       rise_code;

    state_t           state;

    // Everything downstream of this point works on active-high buttons.
    assign btn_pos = BTN_ACTIVE_LOW ? ~btn : btn;

    // Two-flop synchroniser per button bit.
    always_ff @(posedge clock) begin
        // NOTE: clocked state uses non-blocking assignments so every flop
        // samples the pre-edge value of the flop feeding it; with blocking
        // assignments s2 would pick up the new s1 and the chain would collapse.
        if (!reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= btn_pos;
            s2 <= s1;
        end
    end

    // Per-button debounce: the stable level flips only after the synchronised
    // input has disagreed with it for DEBOUNCE_CYCLES consecutive cycles.
    always_ff @(posedge clock) begin
        if (!reset) begin
            // NOTE: the counter array is only three small registers, so it is
            // reset along with everything else; a held button must be seen
            // from a clean count after reset, not from a stale partial count.
            for (int i = 0; i < 3; i++) begin
                cnt[i] <= '0;
            end
            deb      <= '0;
            deb_prev <= '0;
        end else begin
            deb_prev <= deb;
            for (int i = 0; i < 3; i++) begin
                if (s2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    deb[i] <= s2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Classify this cycle's debounced rising edges and encode a single press.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch can be inferred.
        rise       = deb & ~deb_prev;
        rise_one   = 1'b0;
        rise_multi = 1'b0;
        rise_code  = 2'b00;
        unique case (rise)
            3'b001:  begin rise_one = 1'b1; rise_code = 2'b00; end
            3'b010:  begin rise_one = 1'b1; rise_code = 2'b01; end
            3'b100:  begin rise_one = 1'b1; rise_code = 2'b10; end
            3'b000:  ;
            default: rise_multi = 1'b1;
        endcase
    end

    // Press FSM and event register: one event per press, later buttons that
    // join an ongoing press are ignored until all buttons are released.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= IDLE;
            press_valid <= 1'b0;
            press_code  <= 2'b00;
            multi_err   <= 1'b0;
            press_drop  <= 1'b0;
        end else begin
            multi_err  <= 1'b0;
            press_drop <= 1'b0;

            // A pending event leaves on any edge the consumer is ready.
            if (press_valid && press_ready) begin
                press_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (rise_one) begin
                        state <= HELD;
                        // The slot is free if empty or being emptied this edge.
                        if (!press_valid || press_ready) begin
                            press_valid <= 1'b1;
                            press_code  <= rise_code;
                        end else begin
                            press_drop <= 1'b1;
                        end
                    end else if (rise_multi) begin
                        state     <= HELD;
                        multi_err <= 1'b1;
                    end
                end
                HELD: begin
                    if (deb == 3'b000) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign any_held = |deb;

endmodule

// File: doc/btn_press_encoder.md
Name: btn_press_encoder

Overview:
- Input front-end for the genius game.
- Synchronises and debounces the three game buttons and detects press events.
- Encodes each press into the 2-bit symbol code the game FSM compares against the sequence (btn0=00, btn1=01, btn2=10).
- Presents each press as a single event over a valid/ready handshake, replacing the FSM's raw-level button sampling.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive synchronised cycles a button must differ from its stable level before the stable level flips. Legal range 2..(2^CNT_W)-1.
- CNT_W, 5: width of each per-button debounce counter.
- BTN_ACTIVE_LOW, 0: 1 = btn inputs are active-low and are inverted before the synchroniser.

Ports:
- clock  in  1  system clock; all flops are rising-edge.
- reset  in  1  synchronous, active-low reset.
- btn  in  3  raw asynchronous button inputs.
- press_ready  in  1  game FSM accepts the pending event.
- press_valid  out  1  a press event is pending.
- press_code  out  2  symbol code of the pending event.
- multi_err  out  1  one-cycle pulse: two or more buttons became stable-pressed on the same cycle.
- press_drop  out  1  one-cycle pulse: a new event was lost because the pending event was not yet accepted.
- any_held  out  1  the debounced stable vector is non-zero.

Behaviour:
- Reset (reset==0 at a clock edge) clears everything on that edge:
  - sync flops, debounce counters, stable vector deb[2:0] and all outputs go to 0; press_code=00.
  - FSM returns to IDLE.
  - A pending event is discarded.
- Polarity: if BTN_ACTIVE_LOW=1, btn is inverted before the synchroniser. All later logic is active-high.
- Synchroniser: two flops per bit, s1 then s2.
- Debounce, per bit i, each edge:
  - s2[i]==deb[i]: cnt[i]<=0.
  - otherwise, if cnt[i]==DEBOUNCE_CYCLES-1: deb[i]<=s2[i] and cnt[i]<=0.
  - otherwise: cnt[i]<=cnt[i]+1.
  - Any glitch back to the stable level restarts the count.
- Press detection: rise[2:0] = deb & ~deb_prev, where deb_prev is deb registered one cycle.
- FSM state IDLE:
  - rise one-hot: generate an event with the matching code, then go to HELD.
  - rise with two or more bits set: pulse multi_err, generate no event, go to HELD.
- FSM state HELD:
  - Further rises, from other buttons joining, are ignored: no event and no multi_err.
  - deb==000: go to IDLE.
- Code 11 is never issued.
- Event register:
  - A generated event sets press_valid and loads press_code on the next edge.
  - An event transfers on any edge where press_valid && press_ready; press_valid then clears unless a new event is generated on the same edge.
  - Same edge, transfer plus new event: press_valid stays 1 and press_code takes the new code.
  - New event while press_valid=1 and press_ready=0: the new event is dropped, press_drop pulses, and press_code is unchanged.
  - press_code is stable while press_valid=1 and holds its last value while press_valid=0.
- Latency: with btn held clean, press_valid rises on the (DEBOUNCE_CYCLES+3)th edge, counting the first edge that samples btn asserted. This is 7 edges for DEBOUNCE_CYCLES=4.
- Release is debounced the same way. A new press of the same button requires deb to return to 0 and FSM IDLE first.
- Button held through reset release: it is re-detected as a new press after DEBOUNCE_CYCLES+3 edges.
- any_held is a combinational OR of deb.

Test Plan (DEBOUNCE_CYCLES=4, BTN_ACTIVE_LOW=0):
1. btn=001 held 20 cycles, press_ready=1 -> press_valid high for exactly one cycle at edge 7, press_code=00. No further event until release (any_held falls) and re-press.
2. btn[1] toggles 1,0,1,0 with 2-cycle periods, then held 1 -> exactly one event, code 01, 7 edges after the final rising input.
3. press_ready=0; press btn2, release, press btn0 -> press_valid=1, code=10 retained. press_drop pulses once at the btn0 event. press_ready=1 -> press_valid clears the next edge.
4. btn=101 asserted on the same cycle -> multi_err pulses once, press_valid stays 0. After release, btn=010 -> event code 01.
5. btn=001 asserted, then btn=011 two cycles later -> one event code 00, no multi_err, no second event while either button is held.
6. Event pending and btn0 held, reset=0 for one edge -> press_valid=0 and any_held=0 after that edge. After reset returns high with btn0 still held -> new event code 00 at edge 7.
